// File: rtl/sar_seeker.sv
`default_nettype none
// ============================================================================
// Module   : sar_seeker
// Purpose  : Successive-approximation searcher. It drives trial values to an
//            external "ref < trial" comparator and returns the matching ref.
// Revision : 1.0 - initial release
// ============================================================================
module sar_seeker #(
    parameter int WIDTH  = 8,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             cmp_lt,
    output logic [WIDTH-1:0] trial,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CNT_W = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [CNT_W-1:0] c_cnt_load = CNT_W'(SETTLE);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);
    localparam logic [IDX_W-1:0] c_idx_msb  = IDX_W'(WIDTH - 1);
    localparam logic [IDX_W-1:0] c_idx_one  = IDX_W'(1);
    localparam logic [WIDTH-1:0] c_one      = WIDTH'(1);
    localparam logic [WIDTH-1:0] c_msb      = c_one << (WIDTH - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_PROBE = 1'b1
    } state_t;

    state_t           r_state,  w_state_nxt;
    logic [WIDTH-1:0] r_trial,  w_trial_nxt;
    logic [IDX_W-1:0] r_idx,    w_idx_nxt;
    logic [CNT_W-1:0] r_cnt,    w_cnt_nxt;
    logic             r_busy,   w_busy_nxt;
    logic             r_done,   w_done_nxt;
    logic [WIDTH-1:0] r_result, w_result_nxt;

    // Bit currently under test, and the trial with that bit resolved.
    logic [WIDTH-1:0] w_bit;
    logic [WIDTH-1:0] w_resolved;

    assign w_bit      = c_one << r_idx;
    assign w_resolved = cmp_lt ? (r_trial & ~w_bit) : r_trial;

    always_comb begin
        w_state_nxt  = r_state;
        w_trial_nxt  = r_trial;
        w_idx_nxt    = r_idx;
        w_cnt_nxt    = r_cnt;
        w_busy_nxt   = r_busy;
        w_done_nxt   = 1'b0;
        w_result_nxt = r_result;

        case (r_state)
            ST_IDLE: begin
                // A simultaneous abort suppresses the start.
                if (start && !abort) begin
                    w_state_nxt = ST_PROBE;
                    w_trial_nxt = c_msb;
                    w_idx_nxt   = c_idx_msb;
                    w_cnt_nxt   = c_cnt_load;
                    w_busy_nxt  = 1'b1;
                end
            end
            ST_PROBE: begin
                if (abort) begin
                    w_state_nxt = ST_IDLE;
                    w_trial_nxt = '0;
                    w_busy_nxt  = 1'b0;
                end else if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - c_cnt_one;
                end else if (r_idx != '0) begin
                    w_trial_nxt = w_resolved | (w_bit >> 1);
                    w_idx_nxt   = r_idx - c_idx_one;
                    w_cnt_nxt   = c_cnt_load;
                end else begin
                    w_state_nxt  = ST_IDLE;
                    w_result_nxt = w_resolved;
                    w_done_nxt   = 1'b1;
                    w_busy_nxt   = 1'b0;
                    w_trial_nxt  = '0;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_trial  <= '0;
            r_idx    <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_trial  <= w_trial_nxt;
            r_idx    <= w_idx_nxt;
            r_cnt    <= w_cnt_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
            r_result <= w_result_nxt;
        end
    end

    assign trial  = r_trial;
    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_sar_seeker.sv
`default_nettype none
// ============================================================================
// Module   : tb_sar_seeker
// Purpose  : Bench for sar_seeker; instance 0 uses SETTLE=1, instance 1 SETTLE=0.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sar_seeker;

    logic       clk;
    logic       rst_n;
    logic       start_v  [2];
    logic       abort_v  [2];
    logic       cmp_v    [2];
    logic [7:0] ref_v    [2];
    logic [7:0] trial_v  [2];
    logic       busy_v   [2];
    logic       done_v   [2];
    logic [7:0] result_v [2];

    int         n_checks = 0;
    int         n_err    = 0;
    logic [7:0] exp_result [2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign cmp_v[0] = (ref_v[0] < trial_v[0]);
    assign cmp_v[1] = (ref_v[1] < trial_v[1]);

    sar_seeker #(.WIDTH(8), .SETTLE(1)) u_dut_s1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .abort(abort_v[0]),
        .cmp_lt(cmp_v[0]), .trial(trial_v[0]), .busy(busy_v[0]),
        .done(done_v[0]), .result(result_v[0])
    );

    sar_seeker #(.WIDTH(8), .SETTLE(0)) u_dut_s0 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .abort(abort_v[1]),
        .cmp_lt(cmp_v[1]), .trial(trial_v[1]), .busy(busy_v[1]),
        .done(done_v[1]), .result(result_v[1])
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_quiet(input int sel, input string tag);
        check({tag, "_busy"},  {7'd0, busy_v[sel]},  8'd0);
        check({tag, "_trial"}, trial_v[sel],         8'd0);
        check({tag, "_done"},  {7'd0, done_v[sel]},  8'd0);
        check({tag, "_res"},   result_v[sel],        exp_result[sel]);
    endtask

    // Binary-search model: after k decisions the top k bits equal ref,
    // the next bit down is the one being tried, lower bits are zero.
    function automatic logic [7:0] model_trial(input logic [7:0] rv, input int k);
        int hi_mask;
        hi_mask = 256 - (1 << (8 - k));
        return 8'((int'(rv) & hi_mask) | (1 << (7 - k)));
    endfunction

    // Launch a search on instance sel and follow it cycle by cycle.
    // restart_at / abort_at / reset_at inject events after the sample of that
    // cycle offset from the start edge (-1 disables).
    task automatic search(input int sel, input logic [7:0] rv,
                          input int restart_at, input int abort_at, input int reset_at);
        int per;
        int lat;
        per = (sel == 0) ? 2 : 1;
        lat = 8 * per;
        ref_v[sel]   = rv;
        start_v[sel] = 1'b1;
        @(posedge clk); #1;
        start_v[sel] = 1'b0;
        check("launch_busy",  {7'd0, busy_v[sel]}, 8'd1);
        check("launch_done",  {7'd0, done_v[sel]}, 8'd0);
        check("launch_trial", trial_v[sel], 8'h80);
        for (int c = 1; c <= lat; c++) begin
            if (c - 1 == restart_at) start_v[sel] = 1'b1;
            if (c - 1 == abort_at)   abort_v[sel] = 1'b1;
            @(posedge clk); #1;
            start_v[sel] = 1'b0;
            if (c - 1 == abort_at) begin
                abort_v[sel] = 1'b0;
                check_quiet(sel, "abort");
                for (int j = 0; j < 3; j++) begin
                    @(posedge clk); #1;
                    check_quiet(sel, "post_abort");
                end
                return;
            end
            if (c < lat) begin
                check("run_busy",  {7'd0, busy_v[sel]}, 8'd1);
                check("run_done",  {7'd0, done_v[sel]}, 8'd0);
                check("run_trial", trial_v[sel], model_trial(rv, c / per));
            end else begin
                exp_result[sel] = rv;
                check("fin_done",   {7'd0, done_v[sel]}, 8'd1);
                check("fin_busy",   {7'd0, busy_v[sel]}, 8'd0);
                check("fin_trial",  trial_v[sel], 8'd0);
                check("fin_result", result_v[sel], rv);
            end
            if (c == reset_at) begin
                #2 rst_n = 1'b0;
                #1;
                exp_result[0] = 8'd0;
                exp_result[1] = 8'd0;
                check_quiet(sel, "async_rst");
                @(posedge clk); #1;
                rst_n = 1'b1;
                for (int j = 0; j < 3; j++) begin
                    @(posedge clk); #1;
                    check_quiet(sel, "post_rst");
                end
                return;
            end
        end
    endtask

    task automatic idle_cycle(input int sel);
        @(posedge clk); #1;
        check("idle_done", {7'd0, done_v[sel]}, 8'd0);
        check("idle_busy", {7'd0, busy_v[sel]}, 8'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            start_v[i] = 1'b0; abort_v[i] = 1'b0; ref_v[i] = 8'd0; exp_result[i] = 8'd0;
        end
        #12;
        check_quiet(0, "reset_s1");
        check_quiet(1, "reset_s0");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Main search, settle of one cycle per probe.
        search(0, 8'hA5, -1, -1, -1);
        idle_cycle(0);
        check("done_pulse_width", {7'd0, done_v[0]}, 8'd0);

        // Extremes and exhaustive sweep on the zero-settle instance.
        search(1, 8'h00, -1, -1, -1);
        idle_cycle(1);
        search(1, 8'hFF, -1, -1, -1);
        idle_cycle(1);
        for (int v = 0; v < 256; v++) begin
            search(1, 8'(v), -1, -1, -1);
            idle_cycle(1);
        end

        // Zero settle with back-to-back start in the done cycle.
        search(1, 8'h3C, -1, -1, -1);
        search(1, 8'($urandom_range(255)), -1, -1, -1);
        idle_cycle(1);

        // Random refs on the settle instance.
        for (int i = 0; i < 12; i++) begin
            search(0, 8'($urandom), -1, -1, -1);
            idle_cycle(0);
        end

        // Restart attempt while busy is ignored.
        search(0, 8'h69, 5, -1, -1);
        idle_cycle(0);

        // Abort mid-search leaves the previous result in place.
        search(0, 8'hA5, -1, -1, -1);
        idle_cycle(0);
        search(0, 8'h17, -1, 6, -1);
        // Abort landing on the same edge as a decision, and on the final decision.
        search(1, 8'h44, -1, 3, -1);
        search(1, 8'h45, -1, 7, -1);

        // Start together with abort in idle does nothing; lone abort in idle neither.
        start_v[0] = 1'b1; abort_v[0] = 1'b1;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        check_quiet(0, "idle_start_abort");
        @(posedge clk); #1;
        abort_v[0] = 1'b0;
        check_quiet(0, "idle_abort");

        // Asynchronous reset mid-search, then a fresh search.
        search(0, 8'hC3, -1, -1, 7);
        search(0, 8'h5A, -1, -1, -1);
        idle_cycle(0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
